// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the two bus-like connections of the instruction-memory loader:
//   the boot byte stream (valid/ready handshake) and the one-cycle
//   instruction-memory write port.
//
//   Signals:
//     byte_valid  source -> loader   byte_data carries a byte this cycle
//     byte_data   source -> loader   stream byte
//     byte_ready  loader -> source   loader accepts a byte this cycle
//     imem_we     loader -> memory   write strobe, one cycle per word
//     imem_addr   loader -> memory   byte address of the word written
//     imem_wdata  loader -> memory   assembled little-endian word
//
//   Modports:
//     slave   the loader side (consumes bytes, drives the write port)
//     master  the environment side (byte source + memory observer)

interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory of the single-cycle core.
//   A byte stream is accepted over a valid/ready handshake, assembled into
//   little-endian 32-bit words and written one word per one-cycle write
//   strobe, starting at BASE_ADDR. The processor is held in reset until the
//   whole image has been written.
//
//   Ports:
//     CLK      system clock, rising edge
//     RST      synchronous active-high reset
//     start    load request, honoured only in IDLE or DONE
//     len      number of words to load, latched with start
//     bus      byte stream + instruction-memory write port (slave modport)
//     cpu_rst  processor reset hold, active high
//     busy     high while loading or writing
//     done     high once the image is complete
//     err      last requested length exceeded DEPTH_WORDS
//
//   All outputs are registered.

module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  imem_loader_if.slave     bus,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One extra bit so DEPTH_WORDS itself never truncates against len.
  localparam logic [LEN_W:0] DEPTH_LIM = (LEN_W+1)'(DEPTH_WORDS);

  logic [1:0]       state;
  logic [1:0]       byte_cnt;
  logic [LEN_W-1:0] words_left;

  logic too_long;
  logic zero_len;
  logic byte_xfer;
  logic last_word;

  always_comb begin
    too_long  = ({1'b0, len} > DEPTH_LIM);
    zero_len  = (len == '0);
    byte_xfer = bus.byte_valid & bus.byte_ready;
    last_word = (words_left == LEN_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_IDLE;
      byte_cnt       <= '0;
      words_left     <= '0;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= '0;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err           <= too_long;
            words_left    <= len;
            bus.imem_addr <= BASE_ADDR;
            byte_cnt      <= '0;
            if (too_long) begin
              // Rejected: back to IDLE, processor reset left as it was.
              state          <= S_IDLE;
              busy           <= 1'b0;
              done           <= 1'b0;
              bus.byte_ready <= 1'b0;
            end else if (zero_len) begin
              state   <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b0;
            end else begin
              state          <= S_LOAD;
              cpu_rst        <= 1'b1;
              busy           <= 1'b1;
              done           <= 1'b0;
              bus.byte_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (byte_xfer) begin
            case (byte_cnt)
              2'd0:    bus.imem_wdata[7:0]   <= bus.byte_data;
              2'd1:    bus.imem_wdata[15:8]  <= bus.byte_data;
              2'd2:    bus.imem_wdata[23:16] <= bus.byte_data;
              default: bus.imem_wdata[31:24] <= bus.byte_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            // The strobe is raised on the edge taking byte 3 so that it is
            // high for exactly the WRITE cycle.
            if (byte_cnt == 2'd3) begin
              state          <= S_WRITE;
              bus.byte_ready <= 1'b0;
              bus.imem_we    <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          bus.imem_we   <= 1'b0;
          bus.imem_addr <= bus.imem_addr + 32'd4;
          words_left    <= words_left - LEN_W'(1);
          if (last_word) begin
            // Released on the same edge that completes the final write.
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state          <= S_LOAD;
            bus.byte_ready <= 1'b1;
            byte_cnt       <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] len;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader_if ifc ();

  imem_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(64),
    .LEN_W      (16)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .len    (len),
    .bus    (ifc.slave),
    .cpu_rst(cpu_rst),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every write strobe seen must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (ifc.imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                   ifc.imem_addr, ifc.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", ifc.imem_addr, e.addr);
          check("write_data", ifc.imem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one byte and holds it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    logic rdy;
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    waited = 0;
    do begin
      rdy = ifc.byte_ready;
      tick();
      waited++;
    end while (!rdy && waited < 40);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got no byte_ready expected accept of 0x%02h", b);
    end
    ifc.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends a word LSB first; gap idle cycles after bytes 0..2 only, so the
  // next word's first byte is offered during the WRITE cycle.
  task automatic send_word(input logic [31:0] w, input int gap, output int first_wait);
    int wt;
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[8*i +: 8], (i < 3) ? gap : 0, wt);
      if (i == 0) first_wait = wt;
    end
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic two_word_load(input int gap, input string tag);
    int w0, w1, c0;
    do_start(16'd2);
    c0 = cyc;
    check({tag, "_start_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_done"}, 32'(done), 32'd0);
    check({tag, "_start_addr"}, ifc.imem_addr, 32'h0);
    exp_q.push_back('{addr: 32'h0, data: 32'h0010_0513});
    exp_q.push_back('{addr: 32'h4, data: 32'h0020_0593});
    send_word(32'h0010_0513, gap, w0);
    send_word(32'h0020_0593, gap, w1);
    check({tag, "_w2_first_byte_wait"}, 32'(w1), 32'd2);
    check({tag, "_last_write_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_last_write_done"}, 32'(done), 32'd0);
    tick();
    if (gap == 0) check({tag, "_load_cycles"}, 32'(cyc - c0), 32'd10);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_byte_ready"}, 32'(ifc.byte_ready), 32'd0);
  endtask

  initial begin
    int w;
    start          = 1'b0;
    len            = '0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = '0;
    RST            = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_byte_ready", 32'(ifc.byte_ready), 32'd0);
    check("rst_imem_we", 32'(ifc.imem_we), 32'd0);
    check("rst_addr", ifc.imem_addr, 32'h0);
    check("rst_wdata", ifc.imem_wdata, 32'h0);
    RST = 1'b0;
    tick();

    // Two words, continuous stream
    two_word_load(0, "s2");

    // Same image from DONE with gaps
    two_word_load(1, "s3");

    // Over-length rejection, then recovery
    do_reset();
    do_start(16'd65);
    check("s4_err", 32'(err), 32'd1);
    check("s4_cpu_rst", 32'(cpu_rst), 32'd1);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_byte_ready", 32'(ifc.byte_ready), 32'd0);
    repeat (3) tick();
    check("s4_err_held", 32'(err), 32'd1);
    check("s4_done", 32'(done), 32'd0);
    do_start(16'd1);
    check("s4_err_cleared", 32'(err), 32'd0);
    check("s4_busy_after", 32'(busy), 32'd1);
    exp_q.push_back('{addr: 32'h0, data: 32'h0403_0201});
    send_word(32'h0403_0201, 0, w);
    tick();
    check("s4_done_after", 32'(done), 32'd1);

    // Zero length, then reload from DONE
    do_reset();
    do_start(16'd0);
    check("s5_done", 32'(done), 32'd1);
    check("s5_cpu_rst", 32'(cpu_rst), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    do_start(16'd1);
    check("s5_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("s5_reload_done", 32'(done), 32'd0);
    exp_q.push_back('{addr: 32'h0, data: 32'hDDCC_BBAA});
    send_word(32'hDDCC_BBAA, 0, w);
    tick();
    check("s5_final_done", 32'(done), 32'd1);
    check("s5_final_cpu_rst", 32'(cpu_rst), 32'd0);

    // Max length accepted, reset mid-word
    do_reset();
    do_start(16'd64);
    check("s6_err_len64", 32'(err), 32'd0);
    check("s6_busy_len64", 32'(busy), 32'd1);
    send_byte(8'h11, 0, w);
    send_byte(8'h22, 0, w);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("s6_byte_ready", 32'(ifc.byte_ready), 32'd0);
    check("s6_wdata", ifc.imem_wdata, 32'h0);
    check("s6_cpu_rst", 32'(cpu_rst), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_addr", ifc.imem_addr, 32'h0);
    repeat (6) tick();
    check("s6_idle_busy", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the single-cycle core fetches from. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into instruction memory through a one-cycle write port. It holds the processor in reset until the program image is complete.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
DEPTH_WORDS, 64, instruction memory capacity in words; longer loads are rejected.
LEN_W, 16, width of the word-count input.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset.
start  in  1  load request; sampled only in IDLE or DONE.
len  in  LEN_W  number of 32-bit words to load; latched when start is accepted.
byte_valid  in  1  byte_data is valid this cycle.
byte_data  in  8  stream byte.
byte_ready  out  1  loader accepts a byte this cycle.
imem_we  out  1  instruction-memory write strobe; one cycle per word.
imem_addr  out  32  byte address of the word being written.
imem_wdata  out  32  assembled word.
cpu_rst  out  1  processor reset hold; active high.
busy  out  1  high in LOAD and WRITE.
done  out  1  high in DONE.
err  out  1  length rejected.

Behaviour:
- All outputs are registered.
- Reset (RST=1 at a clock edge), regardless of state:
  - state=IDLE.
  - byte_ready=0, imem_we=0, busy=0, done=0, err=0.
  - imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_rst=1.
  - Byte counter and word counter cleared.
  - A partial word is discarded and no write occurs.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE with start=1:
  - err is cleared.
  - len is latched as words_left, imem_addr reloads BASE_ADDR, byte counter is cleared.
  - If len > DEPTH_WORDS: err=1, state becomes IDLE, no writes, cpu_rst unchanged.
  - Else if len == 0: next state DONE.
  - Else: next state LOAD with cpu_rst=1, busy=1, byte_ready=1.
- IDLE/DONE with start=0: hold state.
- LOAD:
  - A byte transfers when byte_valid & byte_ready at an edge.
  - Byte k (k=0..3) is stored in imem_wdata[8k+7:8k] (little-endian); other bytes hold.
  - On the edge accepting byte 3: next state WRITE, byte_ready=0.
  - byte_valid with byte_ready=0 is not consumed; the source holds the byte until ready.
- WRITE:
  - imem_we=1 for exactly this one cycle, with imem_addr and imem_wdata stable.
  - On exit: imem_addr += 4 and words_left -= 1.
  - If words_left was 1: next state DONE. Else: next state LOAD, byte_ready=1, byte counter=0.
  - Minimum throughput is 5 cycles per word (4 byte cycles + 1 write cycle).
- DONE:
  - done=1, busy=0, byte_ready=0, cpu_rst=0; the processor runs from BASE_ADDR.
  - start re-enters the load sequence and cpu_rst reasserts on the next edge.
- start in LOAD or WRITE is ignored.
- imem_addr wraps modulo 2^32, which is unreachable when len ≤ DEPTH_WORDS.
- The core must not be released (cpu_rst=0) before the last write's edge has completed.

Test Plan:
1. Hold RST 2 cycles -> IDLE, cpu_rst=1, all other outputs 0, imem_addr=0x0.
2. start with len=2; stream 13 05 10 00 93 05 20 00, byte_valid continuous -> writes (0x0, 0x00100513) and (0x4, 0x00200593), each imem_we one cycle wide. DONE is reached 10 cycles after LOAD entry; then done=1 and cpu_rst=0.
3. Same stream with byte_valid low on alternate cycles, and a byte presented during WRITE -> that byte is not consumed until the next LOAD cycle; written data is identical to scenario 2.
4. start with len=65 (DEPTH_WORDS=64) -> err=1, no imem_we, state IDLE, cpu_rst=1. A following start with len=1 clears err.
5. start with len=0 -> DONE on the next edge, no imem_we, cpu_rst=0. start from DONE with len=1 and bytes AA BB CC DD -> cpu_rst=1, then write (0x0, 0xDDCCBBAA).
6. RST asserted after 2 bytes of word 1 -> no imem_we, IDLE, imem_wdata=0, cpu_rst=1, byte_ready=0.
